// File: rtl/axi_arb_pkg.sv
// Shared field positions and types for the two-master AXI arbiter.
// Payloads are packed vectors; the constants below locate the ID and LAST fields.
package axi_arb_pkg;

  localparam int ID_W      = 16;
  localparam int ID_MSB    = ID_W - 1;
  localparam int AW_ID_LSB = 0;
  localparam int WLAST_BIT = 0;
  localparam int B_ID_LSB  = 2;
  localparam int R_ID_LSB  = 3;
  localparam int RLAST_BIT = 0;

  typedef logic src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter that freezes its choice while the downstream stalls,
// so the granted payload never changes under valid.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       out_ready,
  output src_t       grant,
  output logic       out_valid
);

  logic pri_q, pri_d;
  logic lock_q, lock_d;
  src_t lock_src_q, lock_src_d;

  always_comb begin
    grant      = src_t'(req[1]);
    pri_d      = pri_q;
    if (lock_q)
      grant = lock_src_q;
    else if (req == 2'b11)
      grant = pri_q;
    out_valid  = en & req[grant];
    // Lock recomputes every cycle, so it drops by itself once the stall ends.
    lock_d     = out_valid & ~out_ready;
    lock_src_d = grant;
    if (out_valid && out_ready)
      pri_d = ~grant;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pri_q      <= 1'b0;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
    end else begin
      pri_q      <= pri_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end

endmodule

// File: rtl/axi_master_arb2.sv
// Two-to-one AXI4 master arbiter: round-robin AW/AR, W ordered by a write-order queue,
// B/R steered back by the ID MSB source tag.
module axi_master_arb2
  import axi_arb_pkg::*;
#(
  parameter int AW_W     = 109,
  parameter int W_W      = 577,
  parameter int B_W      = 18,
  parameter int R_W      = 531,
  parameter int WQ_DEPTH = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [AW_W-1:0] m0_aw_data,
  input  logic            m0_aw_valid,
  output logic            m0_aw_ready,
  input  logic [AW_W-1:0] m1_aw_data,
  input  logic            m1_aw_valid,
  output logic            m1_aw_ready,
  input  logic [W_W-1:0]  m0_w_data,
  input  logic            m0_w_valid,
  output logic            m0_w_ready,
  input  logic [W_W-1:0]  m1_w_data,
  input  logic            m1_w_valid,
  output logic            m1_w_ready,
  output logic [B_W-1:0]  m0_b_data,
  output logic            m0_b_valid,
  input  logic            m0_b_ready,
  output logic [B_W-1:0]  m1_b_data,
  output logic            m1_b_valid,
  input  logic            m1_b_ready,
  input  logic [AW_W-1:0] m0_ar_data,
  input  logic            m0_ar_valid,
  output logic            m0_ar_ready,
  input  logic [AW_W-1:0] m1_ar_data,
  input  logic            m1_ar_valid,
  output logic            m1_ar_ready,
  output logic [R_W-1:0]  m0_r_data,
  output logic            m0_r_valid,
  input  logic            m0_r_ready,
  output logic [R_W-1:0]  m1_r_data,
  output logic            m1_r_valid,
  input  logic            m1_r_ready,
  output logic [AW_W-1:0] s_aw_data,
  output logic            s_aw_valid,
  input  logic            s_aw_ready,
  output logic [W_W-1:0]  s_w_data,
  output logic            s_w_valid,
  input  logic            s_w_ready,
  output logic [AW_W-1:0] s_ar_data,
  output logic            s_ar_valid,
  input  logic            s_ar_ready,
  input  logic [B_W-1:0]  s_b_data,
  input  logic            s_b_valid,
  output logic            s_b_ready,
  input  logic [R_W-1:0]  s_r_data,
  input  logic            s_r_valid,
  output logic            s_r_ready
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Holds every handshake off for the first cycle after reset release.
  logic run_q, run_d;

  src_t aw_gnt, ar_gnt, wq_head, b_sel, r_sel;
  logic aw_out_valid, ar_out_valid;
  logic wq_full, wq_empty, w_active, wq_push, wq_pop;

  src_t             wq_q [WQ_DEPTH];
  src_t             wq_d [WQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rr_arb2 u_aw_arb (
    .clock     (clock),
    .resetn    (resetn),
    .req       ({m1_aw_valid, m0_aw_valid} & {2{run_q}}),
    .en        (~wq_full),
    .out_ready (s_aw_ready),
    .grant     (aw_gnt),
    .out_valid (aw_out_valid)
  );

  rr_arb2 u_ar_arb (
    .clock     (clock),
    .resetn    (resetn),
    .req       ({m1_ar_valid, m0_ar_valid} & {2{run_q}}),
    .en        (1'b1),
    .out_ready (s_ar_ready),
    .grant     (ar_gnt),
    .out_valid (ar_out_valid)
  );

  always_comb begin
    s_aw_valid = aw_out_valid;
    s_aw_data  = aw_gnt ? m1_aw_data : m0_aw_data;
    s_aw_data[AW_ID_LSB+ID_MSB] = aw_gnt;
    m0_aw_ready = aw_out_valid & s_aw_ready & ~aw_gnt;
    m1_aw_ready = aw_out_valid & s_aw_ready & aw_gnt;

    s_ar_valid = ar_out_valid;
    s_ar_data  = ar_gnt ? m1_ar_data : m0_ar_data;
    s_ar_data[AW_ID_LSB+ID_MSB] = ar_gnt;
    m0_ar_ready = ar_out_valid & s_ar_ready & ~ar_gnt;
    m1_ar_ready = ar_out_valid & s_ar_ready & ar_gnt;
  end

  // Write-order queue: the head names the master whose W burst goes next.
  always_comb begin
    wq_full    = (cnt_q == CNT_W'(WQ_DEPTH));
    wq_empty   = (cnt_q == '0);
    wq_head    = wq_q[rd_ptr_q];
    w_active   = run_q & ~wq_empty;
    s_w_data   = wq_head ? m1_w_data : m0_w_data;
    s_w_valid  = w_active & (wq_head ? m1_w_valid : m0_w_valid);
    m0_w_ready = w_active & ~wq_head & s_w_ready;
    m1_w_ready = w_active & wq_head & s_w_ready;
    wq_push    = s_aw_valid & s_aw_ready;
    wq_pop     = s_w_valid & s_w_ready & s_w_data[WLAST_BIT];

    wq_d = wq_q;
    if (wq_push)
      wq_d[wr_ptr_q] = aw_gnt;
    wr_ptr_d = wr_ptr_q + PTR_W'(wq_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(wq_pop);
    cnt_d    = cnt_q + CNT_W'(wq_push) - CNT_W'(wq_pop);
    run_d    = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < WQ_DEPTH; i++)
        wq_q[i] <= 1'b0;
    end else begin
      run_q    <= run_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      wq_q     <= wq_d;
    end
  end

  // Responses: the tag bit picks the master and is cleared before forwarding.
  always_comb begin
    b_sel      = s_b_data[B_ID_LSB+ID_MSB];
    m0_b_data  = s_b_data;
    m0_b_data[B_ID_LSB+ID_MSB] = 1'b0;
    m1_b_data  = m0_b_data;
    m0_b_valid = run_q & s_b_valid & ~b_sel;
    m1_b_valid = run_q & s_b_valid & b_sel;
    s_b_ready  = run_q & (b_sel ? m1_b_ready : m0_b_ready);

    r_sel      = s_r_data[R_ID_LSB+ID_MSB];
    m0_r_data  = s_r_data;
    m0_r_data[R_ID_LSB+ID_MSB] = 1'b0;
    m1_r_data  = m0_r_data;
    m0_r_valid = run_q & s_r_valid & ~r_sel;
    m1_r_valid = run_q & s_r_valid & r_sel;
    s_r_ready  = run_q & (r_sel ? m1_r_ready : m0_r_ready);
  end

endmodule

// File: tb/tb_axi_master_arb2.sv
// Scoreboard bench for axi_master_arb2: queued master sources, expected shell/master
// traffic pushed at drive time and popped on each observed handshake.
module tb_axi_master_arb2;

  localparam int AW_W = 109, W_W = 577, B_W = 18, R_W = 531, WQ_DEPTH = 4;
  localparam int AW_IDB = 15, B_IDB = 17, R_IDB = 18;

  typedef logic [AW_W-1:0] aw_t;
  typedef logic [W_W-1:0]  w_t;
  typedef logic [B_W-1:0]  b_t;
  typedef logic [R_W-1:0]  r_t;

  logic clock = 1'b0;
  logic resetn;
  aw_t  m0_aw_data, m1_aw_data, m0_ar_data, m1_ar_data, s_aw_data, s_ar_data;
  logic m0_aw_valid, m1_aw_valid, m0_aw_ready, m1_aw_ready;
  logic m0_ar_valid, m1_ar_valid, m0_ar_ready, m1_ar_ready;
  w_t   m0_w_data, m1_w_data, s_w_data;
  logic m0_w_valid, m1_w_valid, m0_w_ready, m1_w_ready;
  b_t   m0_b_data, m1_b_data, s_b_data;
  logic m0_b_valid, m1_b_valid, m0_b_ready, m1_b_ready;
  r_t   m0_r_data, m1_r_data, s_r_data;
  logic m0_r_valid, m1_r_valid, m0_r_ready, m1_r_ready;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_ar_valid, s_ar_ready;
  logic s_b_valid, s_b_ready, s_r_valid, s_r_ready;

  always #5 clock = ~clock;

  axi_master_arb2 #(.AW_W(AW_W), .W_W(W_W), .B_W(B_W), .R_W(R_W), .WQ_DEPTH(WQ_DEPTH)) dut (
    .clock(clock), .resetn(resetn),
    .m0_aw_data(m0_aw_data), .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready),
    .m1_aw_data(m1_aw_data), .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready),
    .m0_w_data(m0_w_data), .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready),
    .m1_w_data(m1_w_data), .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready),
    .m0_b_data(m0_b_data), .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready),
    .m1_b_data(m1_b_data), .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready),
    .m0_ar_data(m0_ar_data), .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
    .m1_ar_data(m1_ar_data), .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
    .m0_r_data(m0_r_data), .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
    .m1_r_data(m1_r_data), .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
    .s_aw_data(s_aw_data), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_ar_data(s_ar_data), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_b_data(s_b_data), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_r_data(s_r_data), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready)
  );

  int n_chk = 0, n_pass = 0, aw_hs_cnt = 0;
  bit drv_en = 0, force_v = 0, mon_en = 0;
  bit hs_aw0, hs_aw1, hs_ar0, hs_ar1, hs_w0, hs_w1;

  aw_t src_aw0[$], src_aw1[$], src_ar0[$], src_ar1[$], exp_aw[$], exp_ar[$];
  w_t  src_w0[$], src_w1[$], exp_w[$];
  b_t  exp_b0[$], exp_b1[$];
  r_t  exp_r0[$], exp_r1[$];

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock); #2;
  endtask

  function automatic aw_t mk_aw(input int k);
    aw_t p = '0;
    p[47:16] = $urandom;
    p[14:0]  = 15'(k);
    return p;
  endfunction

  task automatic send_aw(input bit m, input int k);
    aw_t p = mk_aw(k);
    aw_t e = p;
    e[AW_IDB] = m;
    if (m) src_aw1.push_back(p); else src_aw0.push_back(p);
    exp_aw.push_back(e);
  endtask

  task automatic send_ar(input bit m, input int k);
    aw_t p = mk_aw(k);
    aw_t e = p;
    e[AW_IDB] = m;
    if (m) src_ar1.push_back(p); else src_ar0.push_back(p);
    exp_ar.push_back(e);
  endtask

  task automatic send_w(input bit m, input bit last);
    w_t p = '0;
    p[64:1] = {$urandom, $urandom};
    p[0]    = last;
    if (m) src_w1.push_back(p); else src_w0.push_back(p);
    exp_w.push_back(p);
  endtask

  function automatic int pending();
    return exp_aw.size() + exp_ar.size() + exp_w.size() + exp_b0.size() + exp_b1.size()
         + exp_r0.size() + exp_r1.size() + src_aw0.size() + src_aw1.size()
         + src_ar0.size() + src_ar1.size() + src_w0.size() + src_w1.size();
  endfunction

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && pending() != 0; i++) tick();
    check(tag, 640'(pending()), 640'(0));
  endtask

  // Master-side sources: each queue head is presented until its handshake is seen.
  initial begin
    {m0_aw_valid, m1_aw_valid, m0_ar_valid, m1_ar_valid, m0_w_valid, m1_w_valid} = '0;
    {m0_aw_data, m1_aw_data, m0_ar_data, m1_ar_data, m0_w_data, m1_w_data} = '0;
    forever begin
      @(posedge clock); #1;
      if (hs_aw0) void'(src_aw0.pop_front());
      if (hs_aw1) void'(src_aw1.pop_front());
      if (hs_ar0) void'(src_ar0.pop_front());
      if (hs_ar1) void'(src_ar1.pop_front());
      if (hs_w0)  void'(src_w0.pop_front());
      if (hs_w1)  void'(src_w1.pop_front());
      m0_aw_valid = drv_en ? (src_aw0.size() != 0) : force_v;
      m1_aw_valid = drv_en ? (src_aw1.size() != 0) : force_v;
      m0_ar_valid = drv_en ? (src_ar0.size() != 0) : force_v;
      m1_ar_valid = drv_en ? (src_ar1.size() != 0) : force_v;
      m0_w_valid  = drv_en ? (src_w0.size() != 0) : force_v;
      m1_w_valid  = drv_en ? (src_w1.size() != 0) : force_v;
      m0_aw_data = (src_aw0.size() != 0) ? src_aw0[0] : '0;
      m1_aw_data = (src_aw1.size() != 0) ? src_aw1[0] : '0;
      m0_ar_data = (src_ar0.size() != 0) ? src_ar0[0] : '0;
      m1_ar_data = (src_ar1.size() != 0) ? src_ar1[0] : '0;
      m0_w_data  = (src_w0.size() != 0) ? src_w0[0] : '0;
      m1_w_data  = (src_w1.size() != 0) ? src_w1[0] : '0;
    end
  end

  always @(negedge clock) begin
    hs_aw0 = m0_aw_valid && m0_aw_ready;
    hs_aw1 = m1_aw_valid && m1_aw_ready;
    hs_ar0 = m0_ar_valid && m0_ar_ready;
    hs_ar1 = m1_ar_valid && m1_ar_ready;
    hs_w0  = m0_w_valid && m0_w_ready;
    hs_w1  = m1_w_valid && m1_w_ready;
    if (mon_en) begin
      if (s_aw_valid && s_aw_ready) begin
        aw_hs_cnt++;
        if (exp_aw.size() == 0) check("aw_extra", 1, 0);
        else check("s_aw", s_aw_data, exp_aw.pop_front());
      end
      if (s_ar_valid && s_ar_ready) begin
        if (exp_ar.size() == 0) check("ar_extra", 1, 0);
        else check("s_ar", s_ar_data, exp_ar.pop_front());
      end
      if (s_w_valid && s_w_ready) begin
        if (exp_w.size() == 0) check("w_extra", 1, 0);
        else check("s_w", s_w_data, exp_w.pop_front());
      end
      if (m0_b_valid && m0_b_ready) begin
        if (exp_b0.size() == 0) check("b0_extra", 1, 0);
        else check("m0_b", m0_b_data, exp_b0.pop_front());
      end
      if (m1_b_valid && m1_b_ready) begin
        if (exp_b1.size() == 0) check("b1_extra", 1, 0);
        else check("m1_b", m1_b_data, exp_b1.pop_front());
      end
      if (m0_r_valid && m0_r_ready) begin
        if (exp_r0.size() == 0) check("r0_extra", 1, 0);
        else check("m0_r", m0_r_data, exp_r0.pop_front());
      end
      if (m1_r_valid && m1_r_ready) begin
        if (exp_r1.size() == 0) check("r1_extra", 1, 0);
        else check("m1_r", m1_r_data, exp_r1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    r_t rp, re;
    b_t bp, be;
    resetn = 1'b0;
    {s_aw_ready, s_w_ready, s_ar_ready} = 3'b111;
    {m0_b_ready, m1_b_ready, m0_r_ready, m1_r_ready} = 4'b1111;
    s_b_valid = 1'b1; s_r_valid = 1'b1;
    s_b_data = b_t'($urandom); s_r_data = r_t'({$urandom, $urandom});
    force_v = 1'b1;
    repeat (3) tick();

    // Reset with every upstream valid high.
    @(negedge clock);
    check("reset_outs", {m0_aw_ready, m1_aw_ready, m0_w_ready, m1_w_ready, m0_ar_ready,
                         m1_ar_ready, m0_b_valid, m1_b_valid, m0_r_valid, m1_r_valid,
                         s_aw_valid, s_w_valid, s_ar_valid, s_b_ready, s_r_ready}, 0);
    force_v = 1'b0; s_b_valid = 1'b0; s_r_valid = 1'b0;
    tick(); tick();
    resetn = 1'b1; drv_en = 1'b1; mon_en = 1'b1;
    tick();

    // Both masters issue AW at once: m0 first, then m1; W follows queue order.
    send_aw(0, 1); send_aw(1, 2);
    send_w(0, 1);  send_w(1, 1);
    drain("t1_drain");

    // AR from both masters back-to-back alternates m0, m1, ...
    for (int k = 0; k < 3; k++) begin
      send_ar(0, 10 + k); send_ar(1, 20 + k);
    end
    drain("t2_drain");

    // W beats before their AW stall; m1 burst of 4 precedes m0 single beat.
    for (int k = 0; k < 4; k++) send_w(1, k == 3);
    send_w(0, 1);
    tick(); tick(); tick();
    @(negedge clock);
    check("w_early_valid", s_w_valid, 0);
    check("w_early_rdy", {m0_w_ready, m1_w_ready}, 0);
    send_aw(1, 3);
    tick();
    send_aw(0, 4);
    tick();
    @(negedge clock);
    check("t3_m0_wrdy", m0_w_ready, 0);
    check("t3_m1_wrdy", m1_w_ready, 1);
    drain("t3_drain");

    // Queue full: four AWs accepted, the fifth waits for one WLAST pop.
    s_w_ready = 1'b0;
    base = aw_hs_cnt;
    for (int k = 0; k < 5; k++) send_aw(0, 30 + k);
    for (int i = 0; i < 40 && aw_hs_cnt < base + 4; i++) tick();
    tick();
    @(negedge clock);
    check("full_cnt", 640'(aw_hs_cnt), 640'(base + 4));
    check("full_aw_rdy", m0_aw_ready, 0);
    check("full_s_aw_valid", s_aw_valid, 0);
    send_w(0, 1);
    s_w_ready = 1'b1;
    tick();
    @(negedge clock);
    check("pop_cycle_aw_rdy", m0_aw_ready, 0);
    tick();
    @(negedge clock);
    check("after_pop_aw_rdy", m0_aw_ready, 1);
    for (int k = 0; k < 4; k++) send_w(0, 1);
    drain("t4_drain");

    // R tagged for m1 while m1 is not ready.
    rp = r_t'({$urandom, $urandom, $urandom});
    rp[R_IDB-15 +: 16] = 16'h8005;
    re = rp;
    re[R_IDB] = 1'b0;
    s_r_data = rp; s_r_valid = 1'b1; m1_r_ready = 1'b0; m0_r_ready = 1'b1;
    @(negedge clock);
    check("r_m1_valid", m1_r_valid, 1);
    check("r_m0_valid", m0_r_valid, 0);
    check("r_s_ready_low", s_r_ready, 0);
    check("r_m1_data", m1_r_data, re);
    tick();
    m1_r_ready = 1'b1;
    exp_r1.push_back(re);
    #1;
    check("r_s_ready_high", s_r_ready, 1);
    tick();
    s_r_valid = 1'b0;

    // B steering in both directions.
    bp = {16'h0003, 2'b10};
    be = bp;
    s_b_data = bp; s_b_valid = 1'b1; exp_b0.push_back(be);
    #1;
    check("b_m1_valid_low", m1_b_valid, 0);
    tick();
    bp = {16'h8007, 2'b01};
    be = {16'h0007, 2'b01};
    s_b_data = bp; exp_b1.push_back(be);
    #1;
    check("b_m0_valid_low", m0_b_valid, 0);
    tick();
    s_b_valid = 1'b0;
    drain("t5_drain");

    // Stalled m0 AW holds its grant even when m1 joins and has priority.
    s_aw_ready = 1'b0;
    send_aw(0, 6);
    tick();
    send_aw(1, 7);
    tick(); tick();
    @(negedge clock);
    check("hold_valid", s_aw_valid, 1);
    check("hold_data", s_aw_data, exp_aw[0]);
    tick();
    s_aw_ready = 1'b1;
    send_w(0, 1); send_w(1, 1);
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
